// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response handshake bundle between the pipeline and alu_seq
interface alu_seq_if #(parameter int WIDTH = 32);
  logic in_valid;
  logic in_ready;
  logic [4:0] opcode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] result;
  logic [1:0] flags;
  logic div_by_zero;
  logic op_err;
  modport master (
    output in_valid, opcode, a, b, out_ready,
    input in_ready, out_valid, result, flags, div_by_zero, op_err
  );
  modport slave (
    input in_valid, opcode, a, b, out_ready,
    output in_ready, out_valid, result, flags, div_by_zero, op_err
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with single-cycle ops and iterative shift-add MUL / restoring DIV
module alu_seq #(
  parameter int WIDTH = 32,
  parameter bit MULDIV_EN = 1'b1
) (
  input logic clk,
  input logic rst,
  alu_seq_if.slave io
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  typedef enum logic [3:0] {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_MUL, OP_DIV, OP_ILL} op_t;
  state_t state_q, state_d;
  op_t alu_op;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, acc_q, acc_d, result_q, result_d;
  logic [1:0] flags_q, flags_d;
  logic dbz_q, dbz_d, err_q, err_d;
  logic [WIDTH-1:0] quick, mul_acc, div_acc, div_opa, fin;
  logic [WIDTH:0] rem_sh;
  logic ge, done_now, b_zero;
  always_comb begin
    alu_op = OP_ILL;
    case (io.opcode)
      5'b00010, 5'b00011, 5'b11101, 5'b11100: alu_op = OP_ADD;
      5'b00100, 5'b00101, 5'b10010: alu_op = OP_SUB;
      5'b01010, 5'b01011, 5'b00111, 5'b11110: alu_op = OP_AND;
      5'b01100, 5'b01101: alu_op = OP_OR;
      5'b10000, 5'b10001: alu_op = OP_XOR;
      5'b01110: alu_op = OP_NOT;
      5'b00110: alu_op = MULDIV_EN ? OP_MUL : OP_ILL;
      5'b01000: alu_op = MULDIV_EN ? OP_DIV : OP_ILL;
      default: alu_op = OP_ILL;
    endcase
  end
  always_comb begin
    b_zero = io.b == '0;
    quick = alu_op == OP_ADD ? io.a + io.b :
            alu_op == OP_SUB ? io.a - io.b :
            alu_op == OP_AND ? io.a & io.b :
            alu_op == OP_OR  ? io.a | io.b :
            alu_op == OP_XOR ? io.a ^ io.b :
            alu_op == OP_NOT ? ~io.a :
            alu_op == OP_DIV ? '1 : '0;
    mul_acc = acc_q + (opa_q[0] ? opb_q : '0);
    rem_sh = {acc_q, opa_q[WIDTH-1]};
    ge = rem_sh >= {1'b0, opb_q};
    div_acc = ge ? rem_sh[WIDTH-1:0] - opb_q : rem_sh[WIDTH-1:0];
    div_opa = {opa_q[WIDTH-2:0], ge};
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    opa_d = opa_q;
    opb_d = opb_q;
    acc_d = acc_q;
    result_d = result_q;
    flags_d = flags_q;
    dbz_d = dbz_q;
    err_d = err_q;
    done_now = 1'b0;
    fin = '0;
    case (state_q)
      IDLE: if (io.in_valid) begin
        opa_d = io.a;
        opb_d = io.b;
        acc_d = '0;
        cnt_d = CW'(WIDTH);
        dbz_d = alu_op == OP_DIV && b_zero;
        err_d = alu_op == OP_ILL;
        if (alu_op == OP_MUL && !b_zero) state_d = MUL;
        else if (alu_op == OP_DIV && !b_zero) state_d = DIV;
        else begin
          state_d = DONE;
          done_now = 1'b1;
          fin = quick;
        end
      end
      MUL: begin
        opa_d = opa_q >> 1;
        opb_d = opb_q << 1;
        acc_d = mul_acc;
        cnt_d = cnt_q - CW'(1);
        done_now = cnt_q == CW'(1);
        fin = mul_acc;
        state_d = done_now ? DONE : MUL;
      end
      DIV: begin
        opa_d = div_opa;
        acc_d = div_acc;
        cnt_d = cnt_q - CW'(1);
        done_now = cnt_q == CW'(1);
        fin = div_opa;
        state_d = done_now ? DONE : DIV;
      end
      default: state_d = io.out_ready ? IDLE : DONE;
    endcase
    if (done_now) begin
      result_d = fin;
      flags_d = {fin[WIDTH-1], fin == '0};
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      opa_q <= '0;
      opb_q <= '0;
      acc_q <= '0;
      result_q <= '0;
      flags_q <= '0;
      dbz_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      opa_q <= opa_d;
      opb_q <= opb_d;
      acc_q <= acc_d;
      result_q <= result_d;
      flags_q <= flags_d;
      dbz_q <= dbz_d;
      err_q <= err_d;
    end
  end
  assign io.in_ready = state_q == IDLE;
  assign io.out_valid = state_q == DONE;
  assign io.result = result_q;
  assign io.flags = flags_q;
  assign io.div_by_zero = dbz_q;
  assign io.op_err = err_q;
endmodule
